// File: rtl/uart_frame_tx.sv
// Self-framing UART transmitter: a small write FIFO feeds a start/data/parity/stop
// serialiser running at CLKS_PER_BIT clk_sis cycles per bit.
module uart_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 2,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk_sis,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              overflow,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = 4;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 1 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_frame_tx: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] shift;
  logic              par_bit;
  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              push;
  logic              pop;
  logic              baud_last;
  logic              stop_last;
  logic              enter_last_stop;
  logic              pre_last;
  logic              done_next;

  function automatic logic parity_of(input logic [DATA_W-1:0] d);
    return (PARITY == 2) ? ~^d : ^d;
  endfunction

  assign full      = (count == CNT_FULL);
  assign push      = wr_en && !full;
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign stop_last = (state == STOP) && (bit_cnt == STOP_LAST) && baud_last;
  assign pop       = (count != '0) && ((state == IDLE) || stop_last);

  // frame_done is registered, so raise it one edge ahead of the final stop cycle
  assign enter_last_stop = baud_last &&
    ((STOP_BITS == 2) ? ((state == STOP) && (bit_cnt == '0))
                      : ((state == PAR) ||
                         ((state == DATA) && (bit_cnt == DATA_LAST) && (PARITY == 0))));
  assign pre_last  = (state == STOP) && (bit_cnt == STOP_LAST) && (baud_cnt == BAUD_PRE);
  assign done_next = (CLKS_PER_BIT == 1) ? enter_last_stop : pre_last;

  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage and shift path carry no reset; they are only observed under FSM control
  always_ff @(posedge clk_sis) begin
    if (push) mem[wr_ptr] <= wr_data;
    if (pop) begin
      shift   <= mem[rd_ptr];
      par_bit <= parity_of(mem[rd_ptr]);
    end else if (state == DATA && baud_last) begin
      shift <= shift >> 1;
    end
  end

  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_next;
      if (state != IDLE && !baud_last) baud_cnt <= baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= START;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (baud_last) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift[0];
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                state <= PAR;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift[1];
            end
          end
        end
        PAR: begin
          if (baud_last) begin
            state    <= STOP;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt != STOP_LAST) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (pop) begin
              state   <= START;
              bit_cnt <= '0;
              tx      <= 1'b0;
            end else begin
              state   <= IDLE;
              bit_cnt <= '0;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
